mips_perf_counter_unit: RTL and testbench

- Hardware statistics unit for the MIPS-lite pipeline. It replaces the package-level software counter tasks with synthesizable counters.
- Observes up to RETIRE_PORTS retiring instructions per cycle from the WB stage and classifies each one by opcode: arithmetic, logical, memory, branch.
- Maintains total, per-class, taken-branch and active-cycle counts, plus a snapshot bank that the testbench or a debug port reads.

---
 rtl/mips_perf_counter_unit_pkg.sv | 63 ++++++
 rtl/mips_perf_counter_unit_cell.sv | 46 ++++
 rtl/mips_perf_counter_unit.sv | 133 +++++++++++++
 tb/tb_mips_perf_counter_unit.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_perf_counter_unit_pkg.sv
// Shared definitions for the MIPS-lite performance counter unit:
// counter indices, opcode map and the opcode-to-class decoder.
package mips_perf_counter_unit_pkg;

  localparam int RETIRE_PORTS_DEF = 1;
  localparam int OPCODE_DEF       = 6;
  localparam int NUM_CNT          = 7;

  typedef enum logic [2:0] {
    CNT_TOTAL  = 3'd0,
    CNT_ARITH  = 3'd1,
    CNT_LOGIC  = 3'd2,
    CNT_MEM    = 3'd3,
    CNT_BRANCH = 3'd4,
    CNT_TAKEN  = 3'd5,
    CNT_CYCLES = 3'd6
  } perf_cnt_e;

  typedef enum logic [2:0] {
    CLS_ARITH  = 3'd0,
    CLS_LOGIC  = 3'd1,
    CLS_MEM    = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_OTHER  = 3'd4
  } instr_class_e;

  localparam logic [31:0] OP_ADD  = 32'h00;
  localparam logic [31:0] OP_ADDI = 32'h01;
  localparam logic [31:0] OP_SUB  = 32'h02;
  localparam logic [31:0] OP_SUBI = 32'h03;
  localparam logic [31:0] OP_MUL  = 32'h04;
  localparam logic [31:0] OP_MULI = 32'h05;
  localparam logic [31:0] OP_OR   = 32'h06;
  localparam logic [31:0] OP_ORI  = 32'h07;
  localparam logic [31:0] OP_AND  = 32'h08;
  localparam logic [31:0] OP_ANDI = 32'h09;
  localparam logic [31:0] OP_XOR  = 32'h0A;
  localparam logic [31:0] OP_XORI = 32'h0B;
  localparam logic [31:0] OP_LDW  = 32'h0C;
  localparam logic [31:0] OP_STW  = 32'h0D;
  localparam logic [31:0] OP_BZ   = 32'h0E;
  localparam logic [31:0] OP_BEQ  = 32'h0F;
  localparam logic [31:0] OP_JR   = 32'h10;
  localparam logic [31:0] OP_HALT = 32'h11;

  // Opcodes are contiguous per class, so range compares are sufficient.
  function automatic instr_class_e instr_class(input logic [31:0] op);
    instr_class_e cls;
    if (op <= OP_MULI) begin
      cls = CLS_ARITH;
    end else if (op <= OP_XORI) begin
      cls = CLS_LOGIC;
    end else if (op <= OP_STW) begin
      cls = CLS_MEM;
    end else if (op <= OP_HALT) begin
      cls = CLS_BRANCH;
    end else begin
      cls = CLS_OTHER;
    end
    return cls;
  endfunction

endpackage

// File: rtl/mips_perf_counter_unit_cell.sv
// One live statistics counter: adds a small increment each cycle,
// wraps or saturates on carry-out and keeps a sticky overflow flag.
module perf_counter_cell
  import mips_perf_counter_unit_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int SATURATE  = 0,
  parameter int INC_W     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INC_W-1:0]     i_inc,
  input  logic                 i_clear,
  output logic [CNT_WIDTH-1:0] o_value,
  output logic                 o_ovf
);

  localparam int SUM_W = CNT_WIDTH + 1;

  logic [SUM_W-1:0]     w_sum;
  logic [CNT_WIDTH-1:0] r_value;
  logic                 r_ovf;

  assign w_sum = {1'b0, r_value} + SUM_W'(i_inc);

  // Counter update; the carry bit of the widened sum is the overflow event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clear) begin
      r_value <= '0;
      r_ovf   <= 1'b0;
    end else if (w_sum[CNT_WIDTH]) begin
      r_value <= (SATURATE != 0) ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];
      r_ovf   <= 1'b1;
    end else begin
      r_value <= w_sum[CNT_WIDTH-1:0];
      r_ovf   <= r_ovf;
    end
  end

  assign o_value = r_value;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/mips_perf_counter_unit.sv
// Retire-stage statistics unit: classifies retiring instructions, feeds
// seven counter cells and exposes a snapshot bank through a registered read port.
module mips_perf_counter_unit
  import mips_perf_counter_unit_pkg::*;
#(
  parameter int RETIRE_PORTS = RETIRE_PORTS_DEF,
  parameter int CNT_WIDTH    = 32,
  parameter int SATURATE     = 0,
  parameter int OPCODE       = OPCODE_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_cnt_en,
  input  logic                         i_clear,
  input  logic                         i_snap,
  input  logic [RETIRE_PORTS-1:0]      i_ret_valid,
  input  logic [RETIRE_PORTS*OPCODE-1:0] i_ret_opcode,
  input  logic [RETIRE_PORTS-1:0]      i_ret_taken,
  input  logic [2:0]                   i_rd_addr,
  output logic [CNT_WIDTH-1:0]         o_rd_data,
  output logic [NUM_CNT-1:0]           o_ovf,
  output logic                         o_halted
);

  localparam int INC_W = $clog2(RETIRE_PORTS + 1);

  logic [INC_W-1:0]     w_inc   [NUM_CNT];
  logic [CNT_WIDTH-1:0] w_value [NUM_CNT];
  logic [CNT_WIDTH-1:0] r_snap  [NUM_CNT];
  logic [CNT_WIDTH-1:0] w_rd_mux;
  logic [CNT_WIDTH-1:0] r_rd_data;
  logic                 w_halt_ret;
  logic                 r_halted;

  // Lane masking walks lanes oldest-first; a retiring HALT blocks every younger lane.
  always_comb begin
    logic         w_stop;
    logic         w_act;
    logic [31:0]  w_op;
    instr_class_e w_cls;
    for (int k = 0; k < NUM_CNT; k++) begin
      w_inc[k] = '0;
    end
    w_halt_ret = 1'b0;
    w_stop     = r_halted | ~i_cnt_en;
    w_act      = 1'b0;
    w_op       = 32'd0;
    w_cls      = CLS_OTHER;
    for (int i = 0; i < RETIRE_PORTS; i++) begin
      w_op  = 32'(i_ret_opcode[i*OPCODE +: OPCODE]);
      w_cls = instr_class(w_op);
      w_act = i_ret_valid[i] & ~w_stop;
      w_inc[CNT_TOTAL]  = w_inc[CNT_TOTAL]  + INC_W'(w_act);
      w_inc[CNT_ARITH]  = w_inc[CNT_ARITH]  + INC_W'(w_act && (w_cls == CLS_ARITH));
      w_inc[CNT_LOGIC]  = w_inc[CNT_LOGIC]  + INC_W'(w_act && (w_cls == CLS_LOGIC));
      w_inc[CNT_MEM]    = w_inc[CNT_MEM]    + INC_W'(w_act && (w_cls == CLS_MEM));
      w_inc[CNT_BRANCH] = w_inc[CNT_BRANCH] + INC_W'(w_act && (w_cls == CLS_BRANCH));
      w_inc[CNT_TAKEN]  = w_inc[CNT_TAKEN]
                        + INC_W'(w_act && (w_cls == CLS_BRANCH) && i_ret_taken[i]);
      w_halt_ret = w_halt_ret | (w_act & (w_op == OP_HALT));
      w_stop     = w_stop     | (w_act & (w_op == OP_HALT));
    end
    w_inc[CNT_CYCLES] = INC_W'(i_cnt_en & ~r_halted);
  end

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    perf_counter_cell #(
      .CNT_WIDTH(CNT_WIDTH),
      .SATURATE (SATURATE),
      .INC_W    (INC_W)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_inc  (w_inc[k]),
      .i_clear(i_clear),
      .o_value(w_value[k]),
      .o_ovf  (o_ovf[k])
    );
  end

  // Halted latches on a retiring HALT; clear wins over a same-cycle HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
    end else if (i_clear) begin
      r_halted <= 1'b0;
    end else if (w_halt_ret) begin
      r_halted <= 1'b1;
    end else begin
      r_halted <= r_halted;
    end
  end

  // Snapshot samples pre-update live values, giving atomic read-and-clear with clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        r_snap[k] <= '0;
      end
    end else if (i_snap) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        r_snap[k] <= w_value[k];
      end
    end else begin
      for (int k = 0; k < NUM_CNT; k++) begin
        r_snap[k] <= r_snap[k];
      end
    end
  end

  // Read mux; the unused index returns zero.
  always_comb begin
    w_rd_mux = '0;
    if (i_rd_addr < 3'(NUM_CNT)) begin
      w_rd_mux = r_snap[i_rd_addr];
    end else begin
      w_rd_mux = '0;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_mux;
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_halted  = r_halted;

endmodule

// File: tb/tb_mips_perf_counter_unit.sv
// Self-checking bench: three configurations share one stimulus stream and are
// compared every cycle against a behavioural counting model.
module tb_mips_perf_counter_unit;

  localparam int NCFG = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnt_en, clear, snap;
  logic [1:0]  valid, taken;
  logic [11:0] opcode;
  logic [2:0]  rd_addr;

  logic [31:0] w_rd0;
  logic [3:0]  w_rd1, w_rd2;
  logic [6:0]  w_ovf0, w_ovf1, w_ovf2;
  logic        w_h0, w_h1, w_h2;

  int n_cmp = 0;
  int n_err = 0;

  int cfg_p [NCFG] = '{1, 2, 1};
  int cfg_w [NCFG] = '{32, 4, 4};
  int cfg_s [NCFG] = '{0, 0, 1};

  longint m_live [NCFG][7];
  longint m_snap [NCFG][7];
  bit     m_ovf  [NCFG][7];
  bit     m_halt [NCFG];
  longint m_rd   [NCFG];
  longint got    [NCFG][8];

  logic [31:0] dut_rd   [NCFG];
  logic [6:0]  dut_ovf  [NCFG];
  logic        dut_halt [NCFG];

  always #5 clk = ~clk;

  mips_perf_counter_unit u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_cnt_en(cnt_en), .i_clear(clear), .i_snap(snap),
    .i_ret_valid(valid[0:0]), .i_ret_opcode(opcode[5:0]), .i_ret_taken(taken[0:0]),
    .i_rd_addr(rd_addr), .o_rd_data(w_rd0), .o_ovf(w_ovf0), .o_halted(w_h0)
  );

  mips_perf_counter_unit #(.RETIRE_PORTS(2), .CNT_WIDTH(4), .SATURATE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_cnt_en(cnt_en), .i_clear(clear), .i_snap(snap),
    .i_ret_valid(valid), .i_ret_opcode(opcode), .i_ret_taken(taken),
    .i_rd_addr(rd_addr), .o_rd_data(w_rd1), .o_ovf(w_ovf1), .o_halted(w_h1)
  );

  mips_perf_counter_unit #(.RETIRE_PORTS(1), .CNT_WIDTH(4), .SATURATE(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_cnt_en(cnt_en), .i_clear(clear), .i_snap(snap),
    .i_ret_valid(valid[0:0]), .i_ret_opcode(opcode[5:0]), .i_ret_taken(taken[0:0]),
    .i_rd_addr(rd_addr), .o_rd_data(w_rd2), .o_ovf(w_ovf2), .o_halted(w_h2)
  );

  assign dut_rd[0]   = w_rd0;
  assign dut_rd[1]   = {28'd0, w_rd1};
  assign dut_rd[2]   = {28'd0, w_rd2};
  assign dut_ovf[0]  = w_ovf0;
  assign dut_ovf[1]  = w_ovf1;
  assign dut_ovf[2]  = w_ovf2;
  assign dut_halt[0] = w_h0;
  assign dut_halt[1] = w_h1;
  assign dut_halt[2] = w_h2;

  task automatic check(input string name, input int c, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cfg%0d: dut=%0d expected=%0d", name, c, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCFG; c++) begin
      for (int k = 0; k < 7; k++) begin
        m_live[c][k] = 0;
        m_snap[c][k] = 0;
        m_ovf[c][k]  = 1'b0;
      end
      m_halt[c] = 1'b0;
      m_rd[c]   = 0;
    end
  endfunction

  // One clock edge of the counting rules, computed with plain integer arithmetic.
  function automatic void model_step();
    longint inc [7];
    bit     stop, hl;
    int     op;
    longint mx, s, rdn;
    for (int c = 0; c < NCFG; c++) begin
      for (int k = 0; k < 7; k++) inc[k] = 0;
      stop = 1'b0;
      hl   = 1'b0;
      mx   = (longint'(1) << cfg_w[c]) - 1;
      if (cnt_en && !m_halt[c]) begin
        inc[6] = 1;
        for (int l = 0; l < cfg_p[c]; l++) begin
          if (!stop && valid[l]) begin
            op = int'(opcode[l*6 +: 6]);
            inc[0]++;
            if (op <= 5) inc[1]++;
            else if (op <= 11) inc[2]++;
            else if (op <= 13) inc[3]++;
            else if (op <= 17) begin
              inc[4]++;
              if (taken[l]) inc[5]++;
            end
            if (op == 17) begin
              stop = 1'b1;
              hl   = 1'b1;
            end
          end
        end
      end
      rdn = (int'(rd_addr) < 7) ? m_snap[c][int'(rd_addr)] : 0;
      if (snap) for (int k = 0; k < 7; k++) m_snap[c][k] = m_live[c][k];
      if (clear) begin
        for (int k = 0; k < 7; k++) begin
          m_live[c][k] = 0;
          m_ovf[c][k]  = 1'b0;
        end
        m_halt[c] = 1'b0;
      end else begin
        for (int k = 0; k < 7; k++) begin
          s = m_live[c][k] + inc[k];
          if (s > mx) begin
            m_ovf[c][k]  = 1'b1;
            m_live[c][k] = (cfg_s[c] != 0) ? mx : s - (mx + 1);
          end else begin
            m_live[c][k] = s;
          end
        end
        if (hl) m_halt[c] = 1'b1;
      end
      m_rd[c] = rdn;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Every-cycle comparison of all observable outputs against the model.
  always @(negedge clk) begin
    longint e;
    for (int c = 0; c < NCFG; c++) begin
      e = 0;
      for (int k = 0; k < 7; k++) if (m_ovf[c][k]) e |= (longint'(1) << k);
      check("rd_data", c, dut_rd[c], m_rd[c]);
      check("ovf", c, dut_ovf[c], e);
      check("halted", c, dut_halt[c], m_halt[c]);
    end
  end

  task automatic drive1(input logic [5:0] op, input logic tk);
    valid  = 2'b01;
    opcode = {6'd0, op};
    taken  = {1'b0, tk};
  endtask

  task automatic drive2(input logic [5:0] op0, input logic [5:0] op1);
    valid  = 2'b11;
    opcode = {op1, op0};
    taken  = 2'b00;
  endtask

  task automatic do_clear();
    valid = 2'b00;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic snap_read();
    valid = 2'b00;
    snap  = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      @(negedge clk);
      for (int c = 0; c < NCFG; c++) got[c][a] = dut_rd[c];
    end
  endtask

  function automatic logic [5:0] rand_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 3) return 6'h11;
    else if (r < 12) return 6'($urandom_range(18, 63));
    else return 6'($urandom_range(0, 16));
  endfunction

  initial begin
    longint exp1 [7];
    exp1 = '{5, 1, 1, 2, 1, 1, 5};
    rst_n = 1'b1; cnt_en = 1'b0; clear = 1'b0; snap = 1'b0;
    valid = 2'b00; taken = 2'b00; opcode = 12'd0; rd_addr = 3'd0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < NCFG; c++) begin
      check("reset_rd", c, dut_rd[c], 0);
      check("reset_ovf", c, dut_ovf[c], 0);
      check("reset_halted", c, dut_halt[c], 0);
    end
    rst_n = 1'b1;

    // Single-lane mix: ADD, ORI, LDW, BEQ taken, STW.
    cnt_en = 1'b1;
    drive1(6'h00, 1'b0); @(negedge clk);
    drive1(6'h07, 1'b0); @(negedge clk);
    drive1(6'h0C, 1'b0); @(negedge clk);
    drive1(6'h0F, 1'b1); @(negedge clk);
    drive1(6'h0D, 1'b0); @(negedge clk);
    snap_read();
    for (int c = 0; c < NCFG; c++) begin
      for (int k = 0; k < 7; k++) check("t1_cnt", c, got[c][k], exp1[k]);
      check("t1_rd7", c, got[c][7], 0);
      check("t1_ovf", c, dut_ovf[c], 0);
    end

    // Dual lane MUL/XOR, then HALT truncating a younger ADD.
    do_clear();
    repeat (3) begin drive2(6'h04, 6'h0A); @(negedge clk); end
    drive2(6'h11, 6'h00); @(negedge clk);
    check("t2_halted", 1, dut_halt[1], 1);
    repeat (2) begin drive2(6'h00, 6'h00); @(negedge clk); end
    snap_read();
    check("t2_total", 1, got[1][0], 7);
    check("t2_arith", 1, got[1][1], 3);
    check("t2_logic", 1, got[1][2], 3);
    check("t2_branch", 1, got[1][4], 1);
    check("t2_total_p1", 0, got[0][0], 4);
    check("t2_logic_p1", 0, got[0][2], 0);

    // 17 ADDs: 4-bit wrap vs 4-bit saturate.
    do_clear();
    repeat (17) begin drive1(6'h00, 1'b0); @(negedge clk); end
    snap_read();
    check("t3_total", 0, got[0][0], 17);
    check("t3_total_wrap", 1, got[1][0], 1);
    check("t3_total_sat", 2, got[2][0], 15);
    check("t3_ovf0", 0, dut_ovf[0][0], 0);
    check("t3_ovf0", 1, dut_ovf[1][0], 1);
    check("t3_ovf0", 2, dut_ovf[2][0], 1);

    // Atomic snap + clear at total 9.
    do_clear();
    repeat (9) begin drive1(6'h01, 1'b0); @(negedge clk); end
    valid = 2'b00; snap = 1'b1; clear = 1'b1;
    @(negedge clk);
    snap = 1'b0; clear = 1'b0; rd_addr = 3'd0;
    @(negedge clk);
    for (int c = 0; c < NCFG; c++) begin
      check("t4_snapclr", c, dut_rd[c], 9);
      check("t4_ovf", c, dut_ovf[c], 0);
      check("t4_halted", c, dut_halt[c], 0);
    end
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    @(negedge clk);
    for (int c = 0; c < NCFG; c++) check("t4_after", c, dut_rd[c], 0);

    // cnt_en low freezes counting.
    do_clear();
    repeat (3) begin drive1(6'h00, 1'b0); @(negedge clk); end
    cnt_en = 1'b0;
    repeat (4) begin drive1(6'h00, 1'b0); @(negedge clk); end
    snap_read();
    for (int c = 0; c < NCFG; c++) begin
      check("t5_total", c, got[c][0], 3);
      check("t5_arith", c, got[c][1], 3);
      check("t5_cycles", c, got[c][6], 3);
      check("t5_rd7", c, got[c][7], 0);
    end
    cnt_en = 1'b1;

    // Asynchronous reset mid-stream.
    do_clear();
    rd_addr = 3'd0;
    repeat (3) begin drive1(6'h00, 1'b0); @(negedge clk); end
    valid = 2'b00;
    for (int c = 0; c < NCFG; c++) check("t6_pre_rd", c, dut_rd[c], 3);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < NCFG; c++) begin
      check("t6_async_rd", c, dut_rd[c], 0);
      check("t6_async_ovf", c, dut_ovf[c], 0);
      check("t6_async_halted", c, dut_halt[c], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin drive1(6'h00, 1'b0); @(negedge clk); end
    snap_read();
    for (int c = 0; c < NCFG; c++) begin
      check("t6_resume_total", c, got[c][0], 2);
      check("t6_resume_arith", c, got[c][1], 2);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      cnt_en  = ($urandom_range(0, 9) != 0);
      clear   = ($urandom_range(0, 29) == 0);
      snap    = ($urandom_range(0, 3) == 0);
      rd_addr = 3'($urandom_range(0, 7));
      for (int l = 0; l < 2; l++) begin
        valid[l]          = ($urandom_range(0, 3) != 0);
        taken[l]          = 1'($urandom_range(0, 1));
        opcode[l*6 +: 6]  = rand_op();
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
